// File: rtl/hmnoc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hmnoc_pkg
// Brief   : Shared router state encoding and mesh port-index constants.
// Revision: 1.0
// ============================================================================
package hmnoc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

endpackage
`default_nettype wire

// File: rtl/hmnoc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hmnoc_sync_fifo
// Brief   : Registered synchronous FIFO, no fall-through; push refused at full.
// Revision: 1.0
// ============================================================================
module hmnoc_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hmnoc_mcast_router.sv
`default_nettype none
// ============================================================================
// Module  : hmnoc_mcast_router
// Brief   : Single-source multicast router; FIFO head delivered once to each
//           masked destination, popped when all have accepted.
// Revision: 1.0
// ============================================================================
module hmnoc_mcast_router
    import hmnoc_pkg::*;
#(
    parameter  int DATA_BITWIDTH = 16,
    parameter  int LANES         = 1,
    parameter  int NUM_PORTS     = 5,
    parameter  int FIFO_DEPTH    = 4,
    localparam int FW            = DATA_BITWIDTH * LANES,
    localparam int SW            = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SW-1:0]           cfg_src,
    input  logic [NUM_PORTS-1:0]    cfg_dst_mask,
    output logic                    cfg_err,
    input  logic [NUM_PORTS-1:0]    in_valid,
    input  logic [NUM_PORTS*FW-1:0] in_data,
    output logic [NUM_PORTS-1:0]    in_ready,
    output logic [NUM_PORTS-1:0]    out_valid,
    output logic [NUM_PORTS*FW-1:0] out_data,
    input  logic [NUM_PORTS-1:0]    out_ready,
    output logic                    busy,
    output logic [15:0]             flit_count
);

    localparam logic [SW:0] c_num_ports = (SW+1)'(NUM_PORTS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_apply_pend;
    logic [SW-1:0]        r_src;
    logic [SW-1:0]        r_pend_src;
    logic [NUM_PORTS-1:0] r_mask;
    logic [NUM_PORTS-1:0] r_pend_mask;
    logic [NUM_PORTS-1:0] r_served;
    logic                 r_cfg_err;
    logic [15:0]          r_flit_count;

    logic                 w_cfg_acc;
    logic                 w_cfg_bad;
    logic                 w_cfg_ok;
    logic                 w_src_in_mask;
    logic                 w_src_oob;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [FW-1:0]        w_push_data;
    logic [FW-1:0]        w_head;
    logic [FW-1:0]        w_head_gated;
    logic [NUM_PORTS-1:0] w_done;
    logic [NUM_PORTS-1:0] w_deliver;

    assign cfg_ready  = (r_state != DRAIN);
    assign cfg_err    = r_cfg_err;
    assign busy       = (r_state != IDLE);
    assign flit_count = r_flit_count;

    assign w_src_oob = ({1'b0, cfg_src} >= c_num_ports);
    assign w_cfg_acc = cfg_valid && cfg_ready;
    assign w_cfg_bad = (cfg_dst_mask == '0) || w_src_oob || w_src_in_mask;
    assign w_cfg_ok  = w_cfg_acc && !w_cfg_bad;

    // Loop-based select keeps out-of-range cfg_src from indexing past the mask.
    always_comb begin
        w_src_in_mask = 1'b0;
        w_push_data   = '0;
        in_ready      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (cfg_src == SW'(p)) begin
                w_src_in_mask = cfg_dst_mask[p];
            end
            if (r_src == SW'(p)) begin
                w_push_data = in_data[p*FW +: FW];
                in_ready[p] = (r_state == ROUTE) && !w_full;
            end
        end
    end

    assign w_push = |(in_valid & in_ready);

    always_comb begin
        w_state_nxt  = r_state;
        w_apply_pend = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cfg_ok) begin
                    w_state_nxt = ROUTE;
                end
            end
            ROUTE: begin
                if (w_cfg_ok) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_state_nxt  = ROUTE;
                    w_apply_pend = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src       <= '0;
            r_mask      <= '0;
            r_pend_src  <= '0;
            r_pend_mask <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_acc && w_cfg_bad;
            if (r_state == IDLE && w_cfg_ok) begin
                r_src  <= cfg_src;
                r_mask <= cfg_dst_mask;
            end else if (r_state == ROUTE && w_cfg_ok) begin
                r_pend_src  <= cfg_src;
                r_pend_mask <= cfg_dst_mask;
            end else if (w_apply_pend) begin
                r_src  <= r_pend_src;
                r_mask <= r_pend_mask;
            end
        end
    end

    hmnoc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // A destination is finished with the head once served or accepting now.
    assign out_valid    = w_empty ? '0 : (r_mask & ~r_served);
    assign w_deliver    = out_valid & out_ready;
    assign w_done       = ~r_mask | r_served | out_ready;
    assign w_pop        = !w_empty && (&w_done);
    assign w_head_gated = w_empty ? '0 : w_head;
    assign out_data     = {NUM_PORTS{w_head_gated}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_served     <= '0;
            r_flit_count <= '0;
        end else begin
            if (w_pop) begin
                r_served     <= '0;
                r_flit_count <= r_flit_count + 16'd1;
            end else begin
                r_served <= r_served | w_deliver;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hmnoc_mcast_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_hmnoc_mcast_router
// Brief   : Randomized + directed scoreboard bench for hmnoc_mcast_router.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hmnoc_mcast_router;

    localparam int NP    = 5;
    localparam int FW    = 16;
    localparam int SW    = 3;
    localparam int DEPTH = 4;
    localparam int FW3   = 48;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [SW-1:0]   cfg_src;
    logic [NP-1:0]   cfg_dst_mask;
    logic            cfg_err;
    logic [NP-1:0]   in_valid;
    logic [NP*FW-1:0] in_data;
    logic [NP-1:0]   in_ready;
    logic [NP-1:0]   out_valid;
    logic [NP*FW-1:0] out_data;
    logic [NP-1:0]   out_ready;
    logic            busy;
    logic [15:0]     flit_count;

    logic             cfg3_valid;
    logic             cfg3_ready;
    logic [SW-1:0]    cfg3_src;
    logic [NP-1:0]    cfg3_dst_mask;
    logic             cfg3_err;
    logic [NP-1:0]    in3_valid;
    logic [NP*FW3-1:0] in3_data;
    logic [NP-1:0]    in3_ready;
    logic [NP-1:0]    out3_valid;
    logic [NP*FW3-1:0] out3_data;
    logic [NP-1:0]    out3_ready;
    logic             busy3;
    logic [15:0]      flit_count3;

    int n_checks = 0;
    int n_errors = 0;

    hmnoc_mcast_router #(
        .DATA_BITWIDTH (16), .LANES (1), .NUM_PORTS (NP), .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk (clk), .reset (reset),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_src (cfg_src),
        .cfg_dst_mask (cfg_dst_mask), .cfg_err (cfg_err),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
        .out_valid (out_valid), .out_data (out_data), .out_ready (out_ready),
        .busy (busy), .flit_count (flit_count)
    );

    hmnoc_mcast_router #(
        .DATA_BITWIDTH (16), .LANES (3), .NUM_PORTS (NP), .FIFO_DEPTH (DEPTH)
    ) u_dut3 (
        .clk (clk), .reset (reset),
        .cfg_valid (cfg3_valid), .cfg_ready (cfg3_ready), .cfg_src (cfg3_src),
        .cfg_dst_mask (cfg3_dst_mask), .cfg_err (cfg3_err),
        .in_valid (in3_valid), .in_data (in3_data), .in_ready (in3_ready),
        .out_valid (out3_valid), .out_data (out3_data), .out_ready (out3_ready),
        .busy (busy3), .flit_count (flit_count3)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (flit queue with remaining-destination sets)
    localparam int M_IDLE = 0, M_ROUTE = 1, M_DRAIN = 2;
    int              m_state;
    int              m_src, m_psrc;
    logic [NP-1:0]   m_mask, m_pmask;
    logic [15:0]     m_cnt;
    logic            m_err_exp;
    logic [FW-1:0]   m_data[$];
    logic [NP-1:0]   m_rem[$];
    logic [FW-1:0]   exp_q[NP][$];

    initial begin
        logic [NP-1:0] e_ir, e_ov, acc;
        logic          was_empty, bad;
        logic [FW-1:0] d;
        int            s;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_state = M_IDLE; m_src = 0; m_psrc = 0; m_mask = '0; m_pmask = '0;
                m_cnt = '0; m_err_exp = 1'b0;
                m_data.delete(); m_rem.delete();
                for (int i = 0; i < NP; i++) exp_q[i].delete();
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
                check("rst_cfg_err", 64'(cfg_err), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_flit_count", 64'(flit_count), 64'd0);
                check("rst_out_data", 64'(out_data[63:0]), 64'd0);
                check("rst_out_data_hi", 64'(out_data[NP*FW-1:64]), 64'd0);
            end else begin
                e_ir = '0;
                if (m_state == M_ROUTE && m_data.size() < DEPTH) e_ir[m_src] = 1'b1;
                e_ov = (m_data.size() > 0) ? m_rem[0] : '0;
                check("in_ready", 64'(in_ready), 64'(e_ir));
                check("out_valid", 64'(out_valid), 64'(e_ov));
                check("cfg_ready", 64'(cfg_ready), 64'(m_state != M_DRAIN));
                check("busy", 64'(busy), 64'(m_state != M_IDLE));
                check("flit_count", 64'(flit_count), 64'(m_cnt));
                check("cfg_err", 64'(cfg_err), 64'(m_err_exp));
                if (m_data.size() > 0) begin
                    for (int p = 0; p < NP; p++)
                        check("out_data_bcast", 64'(out_data[p*FW +: FW]), 64'(m_data[0]));
                end
                // advance to the state after the coming rising edge
                was_empty = (m_data.size() == 0);
                acc = e_ov & out_ready;
                if (!was_empty) begin
                    m_rem[0] = m_rem[0] & ~acc;
                    if (m_rem[0] == '0) begin
                        void'(m_data.pop_front()); void'(m_rem.pop_front());
                        m_cnt = m_cnt + 16'd1;
                    end
                end
                if (in_valid[m_src] && e_ir[m_src]) begin
                    d = in_data[m_src*FW +: FW];
                    m_data.push_back(d); m_rem.push_back(m_mask);
                    for (int p = 0; p < NP; p++) if (m_mask[p]) exp_q[p].push_back(d);
                end
                s = int'(cfg_src);
                bad = (cfg_dst_mask == '0) || (s >= NP) || (s < NP && cfg_dst_mask[s]);
                m_err_exp = cfg_valid && (m_state != M_DRAIN) && bad;
                if (m_state == M_DRAIN) begin
                    if (was_empty) begin
                        m_src = m_psrc; m_mask = m_pmask; m_state = M_ROUTE;
                    end
                end else if (cfg_valid && !bad) begin
                    if (m_state == M_IDLE) begin
                        m_src = s; m_mask = cfg_dst_mask; m_state = M_ROUTE;
                    end else begin
                        m_psrc = s; m_pmask = cfg_dst_mask; m_state = M_DRAIN;
                    end
                end
            end
        end
    end

    // ---------------- delivery monitor: per-destination ordered scoreboard
    initial begin
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int p = 0; p < NP; p++) begin
                    if (out_valid[p]) begin
                        if (exp_q[p].size() == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL unexpected_delivery port %0d at %0t: got data %0h, expected no flit",
                                     p, $time, out_data[p*FW +: FW]);
                        end else begin
                            e = exp_q[p][0];
                            check("delivery_data", 64'(out_data[p*FW +: FW]), 64'(e));
                            if (out_ready[p]) void'(exp_q[p].pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_cfg(input int src, input logic [NP-1:0] mask);
        cfg_valid = 1'b1; cfg_src = SW'(src); cfg_dst_mask = mask;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic push1(input int port, input logic [FW-1:0] data);
        in_valid = '0; in_valid[port] = 1'b1;
        in_data[port*FW +: FW] = data;
        tick();
        in_valid = '0;
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_src = '0; cfg_dst_mask = '0;
        in_valid = '0; in_data = '0; out_ready = '0;
        cfg3_valid = 1'b0; cfg3_src = '0; cfg3_dst_mask = '0;
        in3_valid = '0; in3_data = '0; out3_ready = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // unicast
        out_ready = '1;
        do_cfg(0, 5'b00010);
        push1(0, 16'h1234);
        repeat (3) tick();
        check("unicast_flit_count", 64'(flit_count), 64'd1);

        // staggered multicast
        do_cfg(0, 5'b11000);
        repeat (2) tick();
        out_ready = '0;
        push1(0, 16'h0A5A);
        out_ready = 5'b01000; tick();
        out_ready = 5'b00000; tick();
        out_ready = 5'b10000; tick();
        out_ready = '0;
        check("stagger_flit_count", 64'(flit_count), 64'd2);
        repeat (2) tick();

        // full FIFO
        do_cfg(1, 5'b00001);
        repeat (2) tick();
        in_valid = 5'b00010;
        for (int i = 0; i < 6; i++) begin
            in_data[1*FW +: FW] = 16'hF000 + 16'(i);
            tick();
        end
        in_valid = '0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = '1;
        repeat (6) tick();
        check("full_flit_count", 64'(flit_count), 64'd6);

        // reconfiguration with two flits queued
        out_ready = '0;
        push1(1, 16'h1111);
        push1(1, 16'h2222);
        do_cfg(2, 5'b00011);
        in_valid = '1;
        in_data = {NP{16'hBEEF}};
        repeat (3) tick();
        check("drain_blocks_input", 64'(in_ready), 64'd0);
        in_valid = '0;
        out_ready = '1;
        repeat (4) tick();
        push1(2, 16'h3333);
        repeat (3) tick();

        // illegal configurations
        do_cfg(0, 5'b00000);
        do_cfg(2, 5'b00100);
        do_cfg(6, 5'b00001);
        repeat (2) tick();

        // reset with three flits queued
        out_ready = '0;
        push1(2, 16'h4444);
        push1(2, 16'h5555);
        push1(2, 16'h6666);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_busy", 64'(busy), 64'd0);
        do_cfg(0, 5'b00000);
        repeat (2) tick();

        // randomized traffic
        do_cfg(0, 5'b01110);
        for (int c = 0; c < 3000; c++) begin
            cfg_valid    = ($urandom_range(0, 15) == 0);
            cfg_src      = SW'($urandom_range(0, 7));
            cfg_dst_mask = NP'($urandom);
            in_valid     = NP'($urandom);
            in_data      = {$urandom, $urandom, $urandom};
            out_ready    = NP'($urandom);
            reset        = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; cfg_valid = 1'b0; in_valid = '0; out_ready = '1;
        repeat (12) tick();
        for (int p = 0; p < NP; p++) check("undelivered_flits", 64'(exp_q[p].size()), 64'd0);

        // LANES=3 unicast on a 48-bit flit
        cfg3_valid = 1'b1; cfg3_src = 3'd0; cfg3_dst_mask = 5'b00010;
        tick();
        cfg3_valid = 1'b0;
        in3_data[0 +: FW3] = 48'h0123_4567_89AB;
        in3_valid = 5'b00001;
        tick();
        in3_valid = '0;
        check("lanes3_out_valid", 64'(out3_valid), 64'(5'b00010));
        check("lanes3_out_data", 64'(out3_data[1*FW3 +: FW3]), 64'h0123_4567_89AB);
        out3_ready = 5'b00010;
        tick();
        check("lanes3_flit_count", 64'(flit_count3), 64'd1);
        check("lanes3_out_valid_after", 64'(out3_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hmnoc_mcast_router.md
HMNOC_MCAST_ROUTER -- requirements
Module: hmnoc_mcast_router

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16: width of one data lane.
REQ-002 SHALL have parameter LANES, default 1: lanes per flit. Flit width FW = DATA_BITWIDTH*LANES; psum use sets LANES = X_dim.
REQ-003 SHALL have parameter NUM_PORTS, default 5: port indices 0 local, 1 north, 2 south, 3 east, 4 west; minimum 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: power of two, minimum 2.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-009 SHALL have port cfg_ready, output, 1 bit: configuration accepted when high together with cfg_valid.
REQ-010 SHALL have port cfg_src, input, SW = clog2(NUM_PORTS) bits: source port index.
REQ-011 SHALL have port cfg_dst_mask, input, NUM_PORTS bits: multicast destination set.
REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a configuration is rejected.
REQ-013 SHALL have port in_valid, input, NUM_PORTS bits: per-port input valid.
REQ-014 SHALL have port in_data, input, NUM_PORTS*FW bits: port p occupies bits [p*FW +: FW].
REQ-015 SHALL have port in_ready, output, NUM_PORTS bits: per-port input ready.
REQ-016 SHALL have port out_valid, output, NUM_PORTS bits: per-port output valid.
REQ-017 SHALL have port out_data, output, NUM_PORTS*FW bits: per-port output data.
REQ-018 SHALL have port out_ready, input, NUM_PORTS bits: per-port output ready.
REQ-019 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-020 SHALL have port flit_count, output, 16 bits: count of flits fully delivered; wraps at 16 bits.

Function
REQ-021 SHALL implement states IDLE, ROUTE and DRAIN.
REQ-022 cfg_ready SHALL be 1 in IDLE and ROUTE, and 0 in DRAIN.
REQ-023 SHALL reject an accepted configuration whose mask is zero, or whose mask contains cfg_src, or whose cfg_src >= NUM_PORTS:
- pulse cfg_err for one cycle;
- make no state or configuration change.
REQ-024 A valid configuration accepted in IDLE SHALL load src and mask and move to ROUTE on the next cycle.
REQ-025 A valid configuration accepted in ROUTE SHALL:
- store as pending;
- move to DRAIN on the next cycle.
REQ-026 In DRAIN, input SHALL be blocked.
- When the FIFO is empty, the pending configuration SHALL be applied and the state SHALL return to ROUTE.
REQ-027 in_ready[src] SHALL be (state==ROUTE && !full); every other in_ready bit SHALL be 0.
- No push is allowed at full, even when a pop occurs in the same cycle.
REQ-028 A push SHALL occur when in_valid[src] && in_ready[src].
REQ-029 Data SHALL pass through a registered FIFO with no fall-through.
- A flit pushed at cycle t SHALL appear on out_valid at cycle t+1 at the earliest.
REQ-030 The FIFO head SHALL be broadcast on every out_data slice.
REQ-031 out_valid[d] SHALL equal !empty && mask[d] && !served[d].
REQ-032 served[d] SHALL set on out_valid[d] && out_ready[d].
- Destinations may accept in different cycles.
- No destination SHALL receive the same flit twice.
REQ-033 A pop SHALL occur in the cycle where every masked destination is either already served or accepting in that cycle.
- On pop, served SHALL clear and flit_count SHALL increment.
REQ-034 Simultaneous push and pop at non-full SHALL leave occupancy unchanged.
REQ-035 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 Ports outside the mask SHALL hold out_valid at 0.

Reset
REQ-037 On reset, state SHALL be IDLE and the FIFO empty.
REQ-038 On reset, served, src, mask, pending and flit_count SHALL be 0.
REQ-039 On reset, cfg_ready SHALL be 1, and cfg_err, busy, in_ready and out_valid SHALL be 0; out_data SHALL be 0.
REQ-040 Reset asserted mid-flit SHALL discard all FIFO contents without delivering partial multicast.

Structure
REQ-041 The state encoding and port-index constants (LOCAL, NORTH, SOUTH, EAST, WEST) SHALL live in the shared package hmnoc_pkg.
REQ-042 The FIFO SHALL be the single sub-module hmnoc_sync_fifo, parametrised by width FW and depth FIFO_DEPTH.

Verification
REQ-043 Scenario "unicast": cfg src=0 mask=5'b00010; push 0x1234 -> at cycle t+1 out_valid=5'b00010 with data 0x1234; after accept, flit_count=1.
REQ-044 Scenario "staggered multicast": mask=5'b11000; port 3 ready at t+1, port 4 ready at t+3:
- exactly one handshake per port;
- pop at t+3.
REQ-045 Scenario "full FIFO": FIFO_DEPTH=4 with out_ready=0.
- After 4 pushes, in_ready[src]=0.
- Releasing out_ready drains 4 flits in order.
REQ-046 Scenario "reconfiguration": cfg in ROUTE with 2 flits queued.
- DRAIN blocks input.
- The new src and mask take effect only after both flits pop.
REQ-047 Scenario "illegal configuration": mask=0, or src=2 with mask=5'b00100 -> cfg_err pulses for one cycle; state unchanged.
REQ-048 Scenario "reset with 3 flits queued": -> all out_valid=0 next cycle; flit_count=0; state IDLE; LANES=3 regression repeats the unicast scenario with a 48-bit flit.
